// File: rtl/lsnn_layer.sv
// ============================================================================
// Module      : lsnn_layer
// Description : Layer of NUM_NEURONS adaptive leaky integrate-and-fire neurons
//               with refractory period and an indexed debug readout.
//               Optional per-neuron spike counters: define LSNN_SPIKE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsnn_layer #(
  parameter int NUM_NEURONS = 4,
  parameter int W           = 8,
  parameter int LEAK_SHIFT  = 1,
  parameter int B0          = 8,
  parameter int ADAPT_INC   = 4,
  parameter int ADAPT_SHIFT = 2,
  parameter int REFRAC      = 2,
  localparam int c_SEL_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step,
  input  logic [NUM_NEURONS*W-1:0] cur_in,
`ifdef LSNN_SPIKE_COUNT_EN
  input  logic                     cnt_clr,
  output logic [W-1:0]             cnt_out,
`endif
  output logic [NUM_NEURONS-1:0]   spike_o,
  output logic                     spike_vld,
  input  logic [c_SEL_W-1:0]       sel,
  output logic [W-1:0]             thr_out,
  output logic [W-1:0]             mem_out
);

  localparam int           c_RW      = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic [W:0]   c_B0      = (W+1)'(B0);
  localparam logic [W:0]   c_INC     = (W+1)'(ADAPT_INC);
  localparam logic [c_RW-1:0] c_REFRAC = c_RW'(REFRAC);

  logic [NUM_NEURONS-1:0][W-1:0] w_thr_all;
  logic [NUM_NEURONS-1:0][W-1:0] w_mem_all;
`ifdef LSNN_SPIKE_COUNT_EN
  logic [NUM_NEURONS-1:0][W-1:0] w_cnt_all;
`endif
  logic                          r_spike_vld;

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
    logic [W-1:0]    r_mem;
    logic [W-1:0]    r_adapt;
    logic [c_RW-1:0] r_refr;
    logic            r_spike;

    logic [W-1:0]    w_cur;
    logic [W:0]      w_thr_sum;
    logic [W:0]      w_v_sum;
    logic [W:0]      w_a_sum;
    logic [W-1:0]    w_thr;
    logic [W-1:0]    w_v;
    logic [W-1:0]    w_d;
    logic [W-1:0]    w_a_next;
    logic [W-1:0]    w_mem_next;
    logic [c_RW-1:0] w_refr_next;
    logic            w_fire;

    assign w_cur = cur_in[gi*W +: W];

    always_comb begin
      // Threshold is taken from the adaptation value before this step's update
      w_thr_sum   = c_B0 + {1'b0, r_adapt};
      w_thr       = w_thr_sum[W] ? '1 : w_thr_sum[W-1:0];
      w_v_sum     = {1'b0, (r_mem >> LEAK_SHIFT)} + {1'b0, w_cur};
      w_v         = w_v_sum[W] ? '1 : w_v_sum[W-1:0];
      w_fire      = (r_refr == '0) && (w_v >= w_thr);
      w_mem_next  = w_v;
      w_refr_next = r_refr;
      if (r_refr != '0) begin
        w_mem_next  = '0;
        w_refr_next = r_refr - 1'b1;
      end else if (w_fire) begin
        w_mem_next  = '0;
        w_refr_next = c_REFRAC;
      end
      w_d      = r_adapt - (r_adapt >> ADAPT_SHIFT);
      w_a_sum  = {1'b0, w_d} + (w_fire ? c_INC : '0);
      w_a_next = w_a_sum[W] ? '1 : w_a_sum[W-1:0];
    end

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        r_mem   <= '0;
        r_adapt <= '0;
        r_refr  <= '0;
        r_spike <= 1'b0;
      end else if (step) begin
        r_mem   <= w_mem_next;
        r_adapt <= w_a_next;
        r_refr  <= w_refr_next;
        r_spike <= w_fire;
      end
    end

    assign spike_o[gi]   = r_spike;
    assign w_thr_all[gi] = w_thr;
    assign w_mem_all[gi] = r_mem;

`ifdef LSNN_SPIKE_COUNT_EN
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        r_cnt <= '0;
      end else if (cnt_clr) begin
        r_cnt <= '0;
      end else if (step && w_fire && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_cnt_all[gi] = r_cnt;
`endif
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_spike_vld <= 1'b0;
    end else begin
      r_spike_vld <= step;
    end
  end

  assign spike_vld = r_spike_vld;

  // Out-of-range indices fall through every match and read zero
  always_comb begin
    thr_out = '0;
    mem_out = '0;
`ifdef LSNN_SPIKE_COUNT_EN
    cnt_out = '0;
`endif
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (sel == c_SEL_W'(k)) begin
        thr_out = w_thr_all[k];
        mem_out = w_mem_all[k];
`ifdef LSNN_SPIKE_COUNT_EN
        cnt_out = w_cnt_all[k];
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/lsnn_layer.md
Name: lsnn_layer

Overview:
- Parametrised layer of NUM_NEURONS adaptive leaky integrate-and-fire (LSNN) neurons sharing one clock and one step strobe.
- Each neuron has its own registered membrane, adaptive threshold and refractory counter.
- Adds per-neuron reset-on-spike, refractory period, saturating arithmetic and indexed debug readout.
- Sits between the input-current front end and the spike router; one `step` equals one network time step.

Parameters:
- NUM_NEURONS, 4, number of independent neurons (>=1)
- W, 8, data width of current, membrane, adaptation and threshold
- LEAK_SHIFT, 1, membrane decay per step: mem >> LEAK_SHIFT
- B0, 8, baseline threshold (W bits)
- ADAPT_INC, 4, adaptation increment applied on a spike
- ADAPT_SHIFT, 2, adaptation decay per step: adapt - (adapt >> ADAPT_SHIFT)
- REFRAC, 2, refractory length in steps after a spike (0 disables)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-high
- step  in  1  advance all neurons one time step this cycle
- cur_in  in  NUM_NEURONS*W  packed input currents; neuron i at [i*W +: W]; sampled only when step=1
- spike_o  out  NUM_NEURONS  registered spike vector of the last step
- spike_vld  out  1  one-cycle pulse, the cycle after each step
- sel  in  max(1,$clog2(NUM_NEURONS))  debug neuron index
- thr_out  out  W  threshold of neuron sel, combinational from registers
- mem_out  out  W  membrane of neuron sel, combinational from registers

Behaviour:
- Reset (rst_n=1, asynchronous) clears mem, adapt, refr, spike_o and spike_vld to 0 for all neurons. thr_out reads B0 after reset.
- thr_i = min(B0 + adapt_i, 2^W-1), computed from the current (pre-update) adapt_i.
- step=0: all state holds; spike_o holds; spike_vld=0.
- step=1, neuron i, all neurons in parallel; results are registered at the same clock edge:
  - refr_i != 0: refr_i <= refr_i-1; mem_i <= 0; spike_i <= 0; cur_in ignored.
  - refr_i == 0: v = min((mem_i >> LEAK_SHIFT) + cur_i, 2^W-1), computed at W+1 bits then saturated.
  - v >= thr_i: spike_i <= 1; mem_i <= 0; refr_i <= REFRAC.
  - else: spike_i <= 0; mem_i <= v.
  - Adaptation updates every step, including refractory steps: d = adapt_i - (adapt_i >> ADAPT_SHIFT), then adapt_i <= min(d + (spike ? ADAPT_INC : 0), 2^W-1).
- spike_vld <= step. spike_o and spike_vld are valid the cycle after step (latency 1).
- Back-to-back steps (step held high) are legal: one update per cycle.
- sel >= NUM_NEURONS: thr_out and mem_out read 0.
- Reset asserted mid-refractory or mid-step aborts the update; state clears immediately.

Optional Feature:
- Macro: LSNN_SPIKE_COUNT_EN.
- Defined:
  - Adds per-neuron W-bit saturating spike counters (hold at 2^W-1), cleared by reset.
  - Adds input port cnt_clr (1 bit, synchronous clear of all counters; clear wins over a simultaneous increment).
  - Adds output port cnt_out (W bits, counter of neuron sel).
- Undefined: no counters, and neither port exists.

Test Plan (default parameters unless stated):
- Reset: assert rst_n, release -> spike_o=0, spike_vld=0, mem_out=0, thr_out=8 for every sel.
- Integration, neuron 0, cur=5, continuous steps -> mem 5, 7, then spike on step 3 (v=8>=8), mem=0, thr_out=12; steps 4-5 refractory, spike 0, mem 0, adapt 3 then 3; step 6 mem=5.
- Saturation, B0=250, cur=200 -> step 1 mem=200, no spike; step 2 v=100+200 saturates to 255 -> spike, mem=0.
- Hold, step=0 for 10 cycles with cur=255 -> no state change, spike_vld stays 0, spike_o unchanged.
- Independence, cur={0,0,0,20} on neurons 3..0 -> only spike_o[0]=1 each non-refractory step; sel=1 gives mem_out=0, thr_out=8; sel=0 tracks neuron 0.
- Async reset, pulse rst_n for less than one clock during neuron 0 refractory -> all state 0 immediately; next step with cur=8 spikes immediately.
